mips_muldiv_unit: RTL and testbench

Iterative multiply/divide engine that owns the HI/LO register pair on the CPU's multiply/divide path. It accepts a MULT/MULTU/DIV/DIVU request through a start/busy/done handshake and computes over 33 cycles. It also serves the move-to-HI/LO writes and drives the HI/LO values read by move-from-HI/LO. Sits beside the ALU in the execute stage; the control path stalls move-from-HI/LO issue while busy is high.

---
 rtl/mips_muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
`timescale 1ns/1ps
// mips_muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// One radix-2 step per clock: a request accepted on edge E0 is written to
// HI/LO on edge E33 and announced by a one-cycle done pulse after that edge.
// Optional build macro MULDIV_ABORT_EN adds an abort input that flushes an
// in-flight operation without touching HI/LO.
module mips_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  mthi_en,
    input  logic                  mtlo_en,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef MULDIV_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    // op[1] selects divide, op[0] selects the signed variant
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [W-1:0]    r_a;          // |multiplicand| or |dividend|
    logic [W-1:0]    r_b;          // |multiplier| or |divisor|
    logic [W-1:0]    r_a_raw;      // dividend as presented, for divide-by-zero
    logic [2*W-1:0]  r_acc;        // product, or {remainder, quotient}
    logic [CW-1:0]   r_count;
    logic            r_neg_res;
    logic            r_neg_rem;
    logic            r_busy;
    logic            r_done;
    logic            r_div_zero;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    // Flush request; tied off when the abort feature is not built
    logic w_abort;
`ifdef MULDIV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Operand conditioning at the accepting edge
    logic         w_a_neg;
    logic         w_b_neg;
    logic [W-1:0] w_a_mag;
    logic [W-1:0] w_b_mag;

    assign w_a_neg = op[0] & src_a[W-1];
    assign w_b_neg = op[0] & src_b[W-1];
    assign w_a_mag = w_a_neg ? (~src_a + 1'b1) : src_a;
    assign w_b_mag = w_b_neg ? (~src_b + 1'b1) : src_b;

    // Multiply step: conditionally add multiplicand into the upper half,
    // then shift the whole accumulator right (multiplier bits drain out
    // of the low half as product bits fill in from the top).
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder, trial-subtract the divisor, keep the difference if it did
    // not go negative and record the quotient bit in the vacated LSB.
    logic [W:0]     w_div_trial;
    logic           w_div_fits;
    logic [W-1:0]   w_div_rem;
    logic [2*W-1:0] w_div_next;

    assign w_div_trial = r_acc[2*W-1:W-1] - {1'b0, r_b};
    assign w_div_fits  = ~w_div_trial[W];
    assign w_div_rem   = w_div_fits ? w_div_trial[W-1:0] : r_acc[2*W-2:W-1];
    assign w_div_next  = {w_div_rem, r_acc[W-2:0], w_div_fits};

    // Sign correction and final result selection for the FIX edge
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic           w_b_zero;
    logic [W-1:0]   w_fix_hi;
    logic [W-1:0]   w_fix_lo;
    logic           w_fix_dz;

    assign w_prod   = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quot   = r_neg_res ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
    assign w_rem    = r_neg_rem ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
    assign w_b_zero = (r_b == '0);

    // Pick the HI/LO values and the divide-by-zero flag for the active op
    always_comb begin
        w_fix_hi = w_prod[2*W-1:W];
        w_fix_lo = w_prod[W-1:0];
        w_fix_dz = 1'b0;
        if (r_op[1]) begin
            if (w_b_zero) begin
                // Conventional MIPS outcome: dividend in HI, all ones in LO
                w_fix_hi = r_a_raw;
                w_fix_lo = '1;
                w_fix_dz = 1'b1;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quot;
            end
        end
    end

    // Control FSM with registered handshake outputs and the HI/LO pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_a        <= '0;
            r_b        <= '0;
            r_a_raw    <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Move-to writes land here; a simultaneous start is
                    // still accepted and its result overwrites them later.
                    if (mthi_en) r_hi <= wdata;
                    if (mtlo_en) r_lo <= wdata;
                    if (start) begin
                        r_op      <= op;
                        r_a       <= w_a_mag;
                        r_b       <= w_b_mag;
                        r_a_raw   <= src_a;
                        r_acc     <= {{W{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
                        r_count   <= '0;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= r_op[1] ? w_div_next : w_mul_next;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST_STEP) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!w_abort) begin
                        r_hi       <= w_fix_hi;
                        r_lo       <= w_fix_lo;
                        r_done     <= 1'b1;
                        r_div_zero <= w_fix_dz;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
`timescale 1ns/1ps
// Self-checking bench for mips_muldiv_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural HI/LO model.
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          mthi_en;
    logic          mtlo_en;
    logic [W-1:0]  wdata;
`ifdef MULDIV_ABORT_EN
    logic          abort;
`endif
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mthi_en  (mthi_en),
        .mtlo_en  (mtlo_en),
        .wdata    (wdata),
`ifdef MULDIV_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation: {div_zero, hi, lo}
    function automatic logic [64:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b01: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Behavioural model: an accepted request completes 33 edges later
    logic [W-1:0] m_hi, m_lo, m_res_hi, m_res_lo;
    logic         m_busy, m_done, m_dz, m_res_dz;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_left <= 0; m_res_hi <= '0; m_res_lo <= '0; m_res_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (!m_busy) begin
                if (mthi_en) m_hi <= wdata;
                if (mtlo_en) m_lo <= wdata;
                if (start) begin
                    {m_res_dz, m_res_hi, m_res_lo} <= ref_result(op, src_a, src_b);
                    m_busy <= 1'b1;
                    m_left <= 33;
                end
            end else begin
`ifdef MULDIV_ABORT_EN
                if (abort) m_busy <= 1'b0; else
`endif
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_hi   <= m_res_hi;
                    m_lo   <= m_res_lo;
                    m_done <= 1'b1;
                    m_dz   <= m_res_dz;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            chk("busy", {64'b0, busy}, {64'b0, m_busy});
            chk("done", {64'b0, done}, {64'b0, m_done});
            chk("div_zero", {64'b0, div_zero}, {64'b0, m_dz});
            chk("hi", {33'b0, hi}, {33'b0, m_hi});
            chk("lo", {33'b0, lo}, {33'b0, m_lo});
        end
        if (done === 1'b1) n_done++;
    end

    // One operation with an optional injected event at cycle inj_cyc:
    // kind 1 = extra start, 2 = mtlo write, 3 = reset pulse, 4 = abort
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_cyc, input int kind,
                         output int lat, output int busy_cycles, output logic dz_seen, output int dones);
        int d0;
        d0 = n_done;
        lat = 0; busy_cycles = 0; dz_seen = 1'b0;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (busy === 1'b1) busy_cycles++;
            if (n == inj_cyc) begin
                case (kind)
                    1: begin start = 1'b1; op = 2'b10; src_a = 32'd50; src_b = 32'd5; end
                    2: begin mtlo_en = 1'b1; wdata = 32'hDEAD_BEEF; end
                    3: begin
                        rst_n = 1'b0; #1;
                        chk("rst_hi", {33'b0, hi}, 65'd0);
                        chk("rst_lo", {33'b0, lo}, 65'd0);
                        chk("rst_busy", {64'b0, busy}, 65'd0);
                    end
`ifdef MULDIV_ABORT_EN
                    4: abort = 1'b1;
`endif
                    default: ;
                endcase
            end
            @(posedge clk); #1;
            start = 1'b0; mtlo_en = 1'b0; rst_n = 1'b1;
`ifdef MULDIV_ABORT_EN
            abort = 1'b0;
`endif
            if (done === 1'b1 && lat == 0) begin
                lat = n;
                dz_seen = div_zero;
            end
        end
        @(negedge clk);
        dones = n_done - d0;
        $display("op=%0d a=%08h b=%08h inj=%0d/%0d lat=%0d busy=%0d hi=%08h lo=%08h dz=%0b dones=%0d",
                 o, a, b, kind, inj_cyc, lat, busy_cycles, hi, lo, dz_seen, dones);
        @(posedge clk); #1;
    endtask

    task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int inj_cyc, input int kind,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
        int lat, bc, nd;
        logic dz;
        do_op(o, a, b, inj_cyc, kind, lat, bc, dz, nd);
        chk({name, "_latency"}, 65'(lat), 65'd33);
        chk({name, "_busy_cycles"}, 65'(bc), 65'd33);
        chk({name, "_dones"}, 65'(nd), 65'd1);
        chk({name, "_hi"}, {33'b0, hi}, {33'b0, exp_hi});
        chk({name, "_lo"}, {33'b0, lo}, {33'b0, exp_lo});
        chk({name, "_dz"}, {64'b0, dz}, {64'b0, exp_dz});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Hard stop if something never terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, nd;
        logic dz;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        mthi_en = 1'b0; mtlo_en = 1'b0; wdata = '0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        chk("reset_hi", {33'b0, hi}, 65'd0);
        chk("reset_lo", {33'b0, lo}, 65'd0);
        chk("reset_busy", {64'b0, busy}, 65'd0);
        chk("reset_done", {64'b0, done}, 65'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pin the reference model on hand-computed cases
        chk("model_mult", ref_result(2'b01, 32'hFFFF_FFFE, 32'd3), {1'b0, 64'hFFFF_FFFF_FFFF_FFFA});
        chk("model_div", ref_result(2'b11, 32'hFFFF_FFF9, 32'd2), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        chk("model_divovf", ref_result(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});
        chk("model_divz", ref_result(2'b10, 32'h64, 32'h0), {1'b1, 64'h0000_0064_FFFF_FFFF});

        run_check("mult_neg", 2'b01, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_check("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_check("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_check("divu", 2'b10, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 1'b0);
        run_check("divu_zero", 2'b10, 32'h64, 32'h0, 0, 0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run_check("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h8000_0000, 1'b0);

        // Move-to-HI in IDLE lands on the next edge
        mthi_en = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mthi_en = 1'b0;
        chk("mthi_idle", {33'b0, hi}, {33'b0, 32'h1234_5678});
        run_check("mtlo_busy", 2'b01, 32'd3, 32'd5, 10, 2, 32'h0, 32'd15, 1'b0);

        // Reset in the middle of a divide: no done afterwards
        do_op(2'b10, 32'd1000, 32'd3, 15, 3, lat, bc, dz, nd);
        chk("rst_mid_dones", 65'(nd), 65'd0);
        chk("rst_mid_hi", {33'b0, hi}, 65'd0);

`ifdef MULDIV_ABORT_EN
        mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        mthi_en = 1'b0; mtlo_en = 1'b0;
        do_op(2'b00, 32'd7, 32'd9, 20, 4, lat, bc, dz, nd);
        chk("abort_dones", 65'(nd), 65'd0);
        chk("abort_busy_cycles", 65'(bc), 65'd20);
        chk("abort_hi", {33'b0, hi}, {33'b0, 32'hAAAA_5555});
        chk("abort_lo", {33'b0, lo}, {33'b0, 32'hAAAA_5555});
`endif

        // Randomized traffic, checked every cycle against the model
        for (int c = 0; c < 6000; c++) begin
            start   = ($urandom_range(0, 2) == 0);
            op      = 2'($urandom_range(0, 3));
            src_a   = pick();
            src_b   = pick();
            mthi_en = ($urandom_range(0, 7) == 0);
            mtlo_en = ($urandom_range(0, 7) == 0);
            wdata   = $urandom;
`ifdef MULDIV_ABORT_EN
            abort   = ($urandom_range(0, 63) == 0);
`endif
            @(posedge clk); #1;
        end
        start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
